frame_packer: RTL
=================

# frame_packer

Byte-framing stage between the frequency-measurement core and the SPI byte sender. It captures each finished measurement word and wraps it as header, sequence number, payload (MSB first) and checksum. It feeds the bytes one at a time to the sender using the sender's enable/busy handshake. A one-deep pending buffer absorbs a measurement that arrives mid-frame.

## Interface
- `PAYLOAD_BYTES`, 4: measurement width in bytes; valid range 1–8.
- `HEADER`, 8'hA5: first byte of every frame.
- `BUSY_TIMEOUT`, 16: clock cycles allowed for `send_busy` to rise after a `send_en` pulse.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `meas_data`  in  8*PAYLOAD_BYTES  measurement result.
- `meas_valid`  in  1  one-cycle strobe; `meas_data` is valid in that cycle.
- `byte_data`  out  8  byte presented to the sender.
- `send_en`  out  1  one-cycle request to send `byte_data`.
- `send_busy`  in  1  sender busy flag.
- `frame_busy`  out  1  high while a frame is in progress.
- `overrun`  out  1  one-cycle pulse when a pending measurement is overwritten.
- `tx_err`  out  1  one-cycle pulse when a frame is aborted on busy timeout.

## Operation
- Frame layout is `HEADER`, `seq`, payload bytes MSB first, then `chk`. Length is PAYLOAD_BYTES+3 bytes.
- `chk` is the 8-bit sum, modulo 256, of `seq` and all payload bytes. `HEADER` is not included.
- `seq` is an 8-bit register, reset to 0. It increments by 1 after every completed frame and wraps from 255 to 0. Aborted frames do not increment it.
- The pending buffer is one word plus a `pend` flag. Every `meas_valid` writes `meas_data` into it and sets `pend`.
  - If `pend` is already set and not being consumed in that cycle, the new word overwrites the old one and `overrun` pulses.
- FSM states:
  - IDLE: if `pend` is set, move the word into the shift register, clear `pend` and go to REQ.
  - REQ: load `byte_data` with the current byte. When `send_busy` is 0, pulse `send_en` and go to WAIT_HI. While `send_busy` is 1, stay in REQ.
  - WAIT_HI: when `send_busy` is 1, go to WAIT_LO. After BUSY_TIMEOUT cycles without it, pulse `tx_err`, drop the rest of the frame and go to IDLE.
  - WAIT_LO: when `send_busy` is 0, go to REQ with the next byte. After the last byte (`chk`), go to IDLE and increment `seq`.
- If `meas_valid` and IDLE consumption of `pend` occur in the same cycle, the old word starts its frame, the new word becomes pending, and there is no overrun.
- `frame_busy` is 1 in every state except IDLE.

## Timing
- Reset values: `byte_data`=0x00, `send_en`=0, `frame_busy`=0, `overrun`=0, `tx_err`=0, `seq`=0, `pend`=0, FSM in IDLE.
- Reset takes effect at the next edge from any state. An in-flight frame is discarded and no pulse is emitted.
- From idle with the sender idle:
  - `meas_valid` at cycle t gives `pend`=1 at t+1.
  - Frame starts (REQ) at t+2.
  - `send_en` with `byte_data`=HEADER at t+2.
- Inter-byte latency: `send_busy` sampled 0 in WAIT_LO at cycle k gives the next `send_en` at k+1.
- `byte_data` is stable from its `send_en` cycle until the next byte is loaded in REQ.
- `send_en` is never high for two consecutive cycles. It is never high while `send_busy` is 1.
- The timeout counter starts at 0 in the cycle after `send_en`. A rise seen in cycle BUSY_TIMEOUT-1 is accepted; none by then aborts.
- Back-to-back frames: after the last WAIT_LO exit, IDLE takes one cycle before the next REQ.

## Test plan
- Reset, then `meas_data`=0x12345678 (PAYLOAD_BYTES=4); the sender model raises busy 2 cycles after `send_en` for 10 cycles.
  - Expect bytes A5, 00, 12, 34, 56, 78, 14.
  - Expect `seq` → 1 and `frame_busy` back to 0.
- Repeat the same word: expect A5, 01, 12, 34, 56, 78, 15. Then run 256 frames: `seq` wraps 0xFF → 0x00, checksums stay correct.
- During a frame, pulse `meas_valid` three times (0x1, 0x2, 0x3):
  - Expect two `overrun` pulses.
  - The next frame carries payload 0x00000003.
- Sender never raises busy: `tx_err` pulses BUSY_TIMEOUT cycles after the header `send_en`, FSM returns to IDLE, `seq` is unchanged.
- Hold `send_busy`=1 at frame start: no `send_en` until busy drops, then `send_en` in the next cycle.
- Assert `rst` during the payload bytes: next cycle all outputs at reset values; a new `meas_valid` starts a frame with seq 00.

Source files
------------

// File: rtl/frame_packer.sv
// Frames each measurement word as HEADER, seq, payload (MSB first), chk and feeds
// the bytes to the SPI sender over its enable/busy handshake; one-deep pending buffer.
module frame_packer #(
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter logic [7:0]  HEADER        = 8'hA5,
  parameter int unsigned BUSY_TIMEOUT  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [8*PAYLOAD_BYTES-1:0] meas_data,
  input  logic                       meas_valid,
  output logic [7:0]                 byte_data,
  output logic                       send_en,
  input  logic                       send_busy,
  output logic                       frame_busy,
  output logic                       overrun,
  output logic                       tx_err
);

  localparam int unsigned PW = 8 * PAYLOAD_BYTES;
  localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(BUSY_TIMEOUT - 1);
  localparam logic [3:0]    CHK_IDX = 4'(PAYLOAD_BYTES + 2);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_HI, WAIT_LO} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   word_q, word_d;
  logic            pend_q, pend_d;
  logic [PW-1:0]   shreg_q, shreg_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      byte_q, byte_d;
  logic [7:0]      seq_q, seq_d;
  logic [7:0]      chk_q, chk_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            consume;
  logic            send_en_c, tx_err_c;

  assign consume = (state_q == IDLE) && pend_q;

  // A new word always lands in the buffer; it only counts as an overrun when the
  // old word is not being moved to the shift register in the same cycle.
  always_comb begin
    word_d = word_q;
    pend_d = pend_q;
    if (meas_valid) begin
      word_d = meas_data;
      pend_d = 1'b1;
    end else if (consume) begin
      pend_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    seq_d     = seq_q;
    chk_d     = chk_q;
    cnt_d     = cnt_q;
    send_en_c = 1'b0;
    tx_err_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          shreg_d = word_q;
          byte_d  = HEADER;
          idx_d   = '0;
          chk_d   = seq_q;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!send_busy) begin
          send_en_c = 1'b1;
          cnt_d     = '0;
          state_d   = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (send_busy) begin
          state_d = WAIT_LO;
        end else if (cnt_q == TO_LAST) begin
          tx_err_c = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_LO: begin
        if (!send_busy) begin
          if (idx_q == CHK_IDX) begin
            seq_d   = seq_q + 8'd1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = REQ;
            if (idx_q == 4'd0) begin
              byte_d = seq_q;
            end else if (idx_q == CHK_IDX - 4'd1) begin
              byte_d = chk_q;
            end else begin
              // Payload byte leaves the top of the shift register and joins the checksum.
              byte_d  = shreg_q[PW-1 -: 8];
              shreg_d = shreg_q << 8;
              chk_d   = chk_q + shreg_q[PW-1 -: 8];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      pend_q  <= 1'b0;
      shreg_q <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      seq_q   <= '0;
      chk_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pend_q  <= pend_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      seq_q   <= seq_d;
      chk_q   <= chk_d;
      cnt_q   <= cnt_d;
    end
  end

  assign byte_data  = byte_q;
  assign frame_busy = (state_q != IDLE);
  assign send_en    = send_en_c && !rst;
  assign tx_err     = tx_err_c && !rst;
  assign overrun    = meas_valid && pend_q && !consume && !rst;

endmodule
